// File: rtl/cv32e40p_ro_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_ro_mon_pkg
// Description : Shared types and default configuration for the ring-oscillator
//               clock-injection monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package cv32e40p_ro_mon_pkg;

    // Default configuration values
    localparam int unsigned c_def_cnt_w        = 16;
    localparam int unsigned c_def_window_edges = 8;
    localparam int unsigned c_def_warmup_edges = 4;
    localparam int unsigned c_def_timeout      = 1024;

    // Controller state encoding
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WARMUP  = 2'd1,
        MEASURE = 2'd2
    } ro_mon_state_e;

endpackage
`default_nettype wire

// File: rtl/cv32e40p_ro_edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_ro_edge_sync
// Description : Two-flop synchroniser followed by a registered rising-edge
//               detector. The edge pulse appears 3 clk after the input rises.
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e40p_ro_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic edge_o
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic r_edge;

    // Synchronise the free-running input and emit a one-cycle pulse on its rise
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_edge  <= 1'b0;
        end else begin
            r_sync1 <= async_i;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_edge  <= r_sync2 & ~r_prev;
        end
    end

    assign edge_o = r_edge;

endmodule
`default_nettype wire

// File: rtl/cv32e40p_ro_monitor_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_ro_monitor_ctrl
// Description : Ring-oscillator clock-injection monitor. Counts core cycles
//               over a fixed number of RO periods and raises sticky fast,
//               slow and stuck alarms.
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e40p_ro_monitor_ctrl
    import cv32e40p_ro_mon_pkg::*;
#(
    parameter int unsigned CNT_W        = c_def_cnt_w,
    parameter int unsigned WINDOW_EDGES = c_def_window_edges,
    parameter int unsigned WARMUP_EDGES = c_def_warmup_edges,
    parameter int unsigned TIMEOUT      = c_def_timeout
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             ro_i,
    input  logic [CNT_W-1:0] thr_lo_i,
    input  logic [CNT_W-1:0] thr_hi_i,
    input  logic             alarm_clr_i,
    output logic             ro_en_o,
    output logic             busy_o,
    output logic             meas_valid_o,
    output logic [CNT_W-1:0] meas_cnt_o,
    output logic             alarm_fast_o,
    output logic             alarm_slow_o,
    output logic             alarm_stuck_o
);

    localparam int unsigned c_gap_w  = $clog2(TIMEOUT + 1);
    localparam int unsigned c_warm_w = $clog2(WARMUP_EDGES + 1);
    localparam int unsigned c_win_w  = $clog2(WINDOW_EDGES + 1);

    localparam logic [CNT_W-1:0]    c_sat       = {CNT_W{1'b1}};
    // The gap counter is loaded with 1 on each edge, so this limit fires
    // exactly TIMEOUT cycles after the last edge pulse.
    localparam logic [c_gap_w-1:0]  c_gap_lim   = c_gap_w'(TIMEOUT - 1);
    localparam logic [c_warm_w-1:0] c_warm_last = c_warm_w'(WARMUP_EDGES - 1);
    localparam logic [c_win_w-1:0]  c_win_last  = c_win_w'(WINDOW_EDGES - 1);

    ro_mon_state_e       r_state;
    logic [c_warm_w-1:0] r_warm_cnt;
    logic [c_win_w-1:0]  r_win_cnt;
    logic [CNT_W-1:0]    r_cyc_cnt;
    logic [c_gap_w-1:0]  r_gap_cnt;
    logic                r_ro_en;
    logic                r_busy;
    logic                r_meas_valid;
    logic [CNT_W-1:0]    r_meas_cnt;
    logic                r_alarm_fast;
    logic                r_alarm_slow;
    logic                r_alarm_stuck;

    logic w_ro_edge;
    logic w_fast;
    logic w_slow;

    cv32e40p_ro_edge_sync u_edge_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (ro_i),
        .edge_o  (w_ro_edge)
    );

    // The running cycle count already includes the closing-edge cycle, so it
    // is the window result; a saturated count is always treated as fast.
    assign w_fast = (r_cyc_cnt > thr_hi_i) || (r_cyc_cnt == c_sat);
    assign w_slow = (r_cyc_cnt < thr_lo_i);

    // Controller FSM with window counting, timeout tracking and sticky alarms
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_warm_cnt    <= '0;
            r_win_cnt     <= '0;
            r_cyc_cnt     <= '0;
            r_gap_cnt     <= '0;
            r_ro_en       <= 1'b0;
            r_busy        <= 1'b0;
            r_meas_valid  <= 1'b0;
            r_meas_cnt    <= '0;
            r_alarm_fast  <= 1'b0;
            r_alarm_slow  <= 1'b0;
            r_alarm_stuck <= 1'b0;
        end else begin
            r_meas_valid <= 1'b0;

            // Clear first so any set below on the same cycle takes priority
            if (alarm_clr_i) begin
                r_alarm_fast  <= 1'b0;
                r_alarm_slow  <= 1'b0;
                r_alarm_stuck <= 1'b0;
            end

            if (!en_i) begin
                r_state    <= IDLE;
                r_ro_en    <= 1'b0;
                r_busy     <= 1'b0;
                r_warm_cnt <= '0;
                r_win_cnt  <= '0;
                r_cyc_cnt  <= '0;
                r_gap_cnt  <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state    <= WARMUP;
                        r_ro_en    <= 1'b1;
                        r_busy     <= 1'b1;
                        r_warm_cnt <= '0;
                        r_win_cnt  <= '0;
                        r_cyc_cnt  <= '0;
                        r_gap_cnt  <= '0;
                    end
                    WARMUP: begin
                        if (w_ro_edge) begin
                            r_gap_cnt <= c_gap_w'(1);
                            if (r_warm_cnt == c_warm_last) begin
                                // This edge opens the first window
                                r_state    <= MEASURE;
                                r_warm_cnt <= '0;
                                r_win_cnt  <= '0;
                                r_cyc_cnt  <= CNT_W'(1);
                            end else begin
                                r_warm_cnt <= r_warm_cnt + c_warm_w'(1);
                            end
                        end else if (r_gap_cnt == c_gap_lim) begin
                            r_alarm_stuck <= 1'b1;
                            r_warm_cnt    <= '0;
                            r_gap_cnt     <= '0;
                        end else begin
                            r_gap_cnt <= r_gap_cnt + c_gap_w'(1);
                        end
                    end
                    MEASURE: begin
                        if (r_cyc_cnt != c_sat) begin
                            r_cyc_cnt <= r_cyc_cnt + CNT_W'(1);
                        end
                        if (w_ro_edge) begin
                            r_gap_cnt <= c_gap_w'(1);
                            if (r_win_cnt == c_win_last) begin
                                // Close this window and open the next one
                                r_win_cnt    <= '0;
                                r_cyc_cnt    <= CNT_W'(1);
                                r_meas_cnt   <= r_cyc_cnt;
                                r_meas_valid <= 1'b1;
                                if (w_fast) begin
                                    r_alarm_fast <= 1'b1;
                                end
                                if (w_slow) begin
                                    r_alarm_slow <= 1'b1;
                                end
                            end else begin
                                r_win_cnt <= r_win_cnt + c_win_w'(1);
                            end
                        end else if (r_gap_cnt == c_gap_lim) begin
                            r_alarm_stuck <= 1'b1;
                            r_state       <= WARMUP;
                            r_warm_cnt    <= '0;
                            r_win_cnt     <= '0;
                            r_cyc_cnt     <= '0;
                            r_gap_cnt     <= '0;
                        end else begin
                            r_gap_cnt <= r_gap_cnt + c_gap_w'(1);
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_ro_en <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ro_en_o       = r_ro_en;
    assign busy_o        = r_busy;
    assign meas_valid_o  = r_meas_valid;
    assign meas_cnt_o    = r_meas_cnt;
    assign alarm_fast_o  = r_alarm_fast;
    assign alarm_slow_o  = r_alarm_slow;
    assign alarm_stuck_o = r_alarm_stuck;

endmodule
`default_nettype wire

// File: doc/cv32e40p_ro_monitor_ctrl.md
Name: cv32e40p_ro_monitor_ctrl

Overview:
- Controller for the on-die ring-oscillator clock-injection countermeasure.
- Enables the ring oscillator, synchronises its free-running output into the core clock domain, and counts core clock cycles over a fixed number of RO periods.
- Compares each count against programmable bounds and raises sticky alarms:
  - fast: clock glitch or overclock;
  - slow: clock stretch;
  - stuck: RO dead or suppressed.
- Sits beside the core; its alarms feed the security/reset logic.

Parameters:
- CNT_W, 16, width of the measurement counter and thresholds.
- WINDOW_EDGES, 8, RO rising edges per measurement window (>=1).
- WARMUP_EDGES, 4, RO rising edges discarded after enable (>=1).
- TIMEOUT, 1024, max core cycles between RO edges before the stuck alarm fires (>=4).

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous, active-high reset.
- en_i  input  1  monitor enable; level-sensitive.
- ro_i  input  1  asynchronous ring-oscillator output.
- thr_lo_i  input  CNT_W  lower bound; a count strictly below it is slow.
- thr_hi_i  input  CNT_W  upper bound; a count strictly above it is fast.
- alarm_clr_i  input  1  clears all sticky alarms.
- ro_en_o  output  1  ring-oscillator enable.
- busy_o  output  1  FSM not in IDLE.
- meas_valid_o  output  1  one-cycle pulse: meas_cnt_o updated.
- meas_cnt_o  output  CNT_W  last completed window count.
- alarm_fast_o  output  1  sticky fast alarm.
- alarm_slow_o  output  1  sticky slow alarm.
- alarm_stuck_o  output  1  sticky stuck alarm.

Behaviour:
- Reset: state IDLE; all outputs 0; all counters 0.
- Edge detection:
  - ro_i passes through a 2-FF synchroniser, then a rising-edge detector.
  - The edge pulse (ro_edge) is asserted 3 clk after the ro_i rise.
  - ro_i must be slower than clk/4; faster RO is out of spec.
- FSM:
  - IDLE: ro_en_o=0. en_i=1 -> WARMUP, with edge and gap counters cleared.
  - WARMUP: ro_en_o=1. Counts ro_edge. The WARMUP_EDGES-th edge -> MEASURE; that edge opens the first window with cycle counter = 0.
  - MEASURE: ro_en_o=1.
    - Cycle counter increments by 1 each clk and saturates at 2^CNT_W-1.
    - The window closes on the WINDOW_EDGES-th ro_edge after the opening edge.
    - At the closing edge: count captured, counter reset to 0, and the next window opens on the same cycle (back-to-back windows, no gap).
    - Result: an RO period of exactly P clk gives a count of WINDOW_EDGES*P.
- Result timing:
  - meas_cnt_o and meas_valid_o are registered 1 cycle after the closing edge.
  - Alarms are set on the same cycle as meas_valid_o.
  - count > thr_hi_i sets alarm_fast_o; count < thr_lo_i sets alarm_slow_o.
  - Equality with either bound raises nothing.
  - A saturated count counts as > thr_hi_i.
  - Thresholds are sampled at the closing edge.
- Stuck detection:
  - The gap counter runs in WARMUP and MEASURE and resets on every ro_edge.
  - Gap reaching TIMEOUT: set alarm_stuck_o, go to WARMUP (warmup count cleared, ro_en_o stays 1), no meas_valid_o.
- Abort:
  - en_i=0 in any state -> IDLE on the next cycle, ro_en_o=0 on that same next cycle.
  - Any partial window is discarded and no meas_valid_o is issued.
  - Alarms and meas_cnt_o are retained.
- Alarm clear:
  - alarm_clr_i clears all alarms next cycle.
  - Simultaneous set and clear on the same alarm: set wins.
  - alarm_clr_i does not affect the FSM.
- Reset mid-operation: returns to the full reset state; alarms are cleared.

Decomposition:
- Package cv32e40p_ro_mon_pkg holds:
  - the state enum ro_mon_state_e {IDLE, WARMUP, MEASURE};
  - default localparams for CNT_W, WINDOW_EDGES, WARMUP_EDGES and TIMEOUT.
- Sub-module cv32e40p_ro_edge_sync: 2-FF synchroniser plus rising-edge pulse, ports clk, rst, async_i, edge_o.

Test Plan:
- Config for the period tests: WINDOW_EDGES=4, WARMUP_EDGES=2, thr 36..44.
- RO period 10 clk, en_i=1 -> meas_cnt_o=40 and meas_valid_o every 40 clk; no alarms; busy_o=1, ro_en_o=1.
- RO period 12 clk -> meas_cnt_o=48, alarm_fast_o=1 on the valid cycle; stays set after the period returns to 10 until alarm_clr_i.
- RO period 8 clk -> meas_cnt_o=32, alarm_slow_o=1. Period 9 (cnt 36 = thr_lo) -> no alarm.
- TIMEOUT=64, ro_i held low during MEASURE -> alarm_stuck_o=1 exactly 64 clk after the last edge; FSM in WARMUP; restarting the RO yields a valid count after 2+4 edges.
- en_i dropped 2 edges into a window -> next cycle IDLE, ro_en_o=0, no meas_valid_o; meas_cnt_o keeps its prior 40.
- alarm_clr_i pulsed on the same cycle as a fast result -> alarm_fast_o stays 1. rst mid-MEASURE -> all outputs 0 next cycle.
